// File: rtl/accum_sequencer_if.sv
// Bundle between accum_sequencer and its neighbours: upstream operand stream,
// carry-save accumulator handshake and the result/status outputs.
interface accum_sequencer_if #(
  parameter int INPUT_LENGTH  = 16,
  parameter int OUTPUT_LENGTH = 32,
  parameter int COUNT_WIDTH   = 8
);
  logic                     iStart;
  logic [COUNT_WIDTH-1:0]   iCount;
  logic [INPUT_LENGTH-1:0]  iData;
  logic                     iValid;
  logic                     oDataReady;
  logic                     oAccumulate;
  logic                     oTerminate;
  logic [INPUT_LENGTH-1:0]  oA;
  logic                     iAccReady;
  logic [OUTPUT_LENGTH-1:0] iAccRes;
  logic                     iAccDone;
  logic [OUTPUT_LENGTH-1:0] oResult;
  logic                     oResultValid;
  logic                     oBusy;

  // Sequencer side
  modport slave (
    input  iStart, iCount, iData, iValid, iAccReady, iAccRes, iAccDone,
    output oDataReady, oAccumulate, oTerminate, oA, oResult, oResultValid, oBusy
  );

  // Environment side (operand source, accumulator, result consumer)
  modport master (
    output iStart, iCount, iData, iValid, iAccReady, iAccRes, iAccDone,
    input  oDataReady, oAccumulate, oTerminate, oA, oResult, oResultValid, oBusy
  );
endinterface

// File: rtl/accum_sequencer.sv
// Initiator for the carry-save accumulator: pulls a batch of operands from an
// upstream valid/ready stream, issues each as a one-cycle accumulate pulse,
// then terminates the batch and captures the final sum.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for iStart; count latched on start
// FETCH     | upstream ready (only while accumulator ready); take operand
// ISSUE     | one-cycle accumulate pulse, counter decremented
// SETTLE    | one dead cycle so a stale accumulator ready is not trusted
// WAIT_RDY  | wait for accumulator ready, then next operand or terminate
// TERM      | one-cycle terminate pulse
// WAIT_DONE | wait for accumulator done, capture its result
// OUT       | one-cycle result-valid pulse
module accum_sequencer #(
  parameter int INPUT_LENGTH  = 16,
  parameter int OUTPUT_LENGTH = 32,
  parameter int COUNT_WIDTH   = 8
) (
  input  logic               iClk,
  input  logic               iRst,
  accum_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE, FETCH, ISSUE, SETTLE, WAIT_RDY, TERM, WAIT_DONE, OUT
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = '0;

  state_t                   state_q, state_d;
  logic [COUNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [INPUT_LENGTH-1:0]  a_q, a_d;
  logic [OUTPUT_LENGTH-1:0] res_q, res_d;

  logic data_ready;
  logic accumulate;
  logic terminate;
  logic result_valid;

  // State and datapath registers; reset drops any batch in flight.
  always_ff @(posedge iClk) begin
    if (!iRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      res_q   <= res_d;
    end
  end

  // Next-state, counter/operand/result updates and handshake outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    res_d        = res_q;
    data_ready   = 1'b0;
    accumulate   = 1'b0;
    terminate    = 1'b0;
    result_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.iStart) begin
          cnt_d   = bus.iCount;
          state_d = (bus.iCount != CNT_ZERO) ? FETCH : TERM;
        end
      end
      FETCH: begin
        data_ready = bus.iAccReady;
        if (bus.iAccReady && bus.iValid) begin
          a_d     = bus.iData;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        accumulate = 1'b1;
        cnt_d      = cnt_q - CNT_ONE;
        state_d    = SETTLE;
      end
      SETTLE: begin
        state_d = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (bus.iAccReady) begin
          state_d = (cnt_q != CNT_ZERO) ? FETCH : TERM;
        end
      end
      TERM: begin
        terminate = 1'b1;
        state_d   = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.iAccDone) begin
          res_d   = bus.iAccRes;
          state_d = OUT;
        end
      end
      OUT: begin
        result_valid = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.oDataReady   = data_ready;
  assign bus.oAccumulate  = accumulate;
  assign bus.oTerminate   = terminate;
  assign bus.oA           = a_q;
  assign bus.oResult      = res_q;
  assign bus.oResultValid = result_valid;
  assign bus.oBusy        = (state_q != IDLE);

endmodule

// File: doc/accum_sequencer.md
Name: accum_sequencer

Overview:
- Initiator side of the carry-save accumulator handshake.
- Takes a batch of N operands from an upstream valid/ready stream and issues each one to the accumulator as a one-cycle accumulate pulse, pacing on accumulator ready.
- After the last operand it issues terminate, waits for done, then captures and presents the final sum.
- Sits between the datapath that produces operands and carry_save_accumulator, replacing bench-style manual driving.

Parameters:
- INPUT_LENGTH, 16, operand width; must match the accumulator.
- OUTPUT_LENGTH, 32, result width; must match the accumulator.
- COUNT_WIDTH, 8, width of the batch-size field.

Ports:
- iClk  in  1  clock; all logic on the rising edge.
- iRst  in  1  reset, synchronous, active-low.
- iStart  in  1  start-of-batch pulse; sampled only in IDLE.
- iCount  in  COUNT_WIDTH  number of operands in the batch; latched with iStart.
- iData  in  INPUT_LENGTH  upstream operand.
- iValid  in  1  upstream operand valid.
- oDataReady  out  1  upstream ready; a transfer occurs when iValid && oDataReady.
- oAccumulate  out  1  to accumulator iAccumulate; one-cycle pulse.
- oTerminate  out  1  to accumulator iTerminate; one-cycle pulse.
- oA  out  INPUT_LENGTH  to accumulator iA; registered.
- iAccReady  in  1  from accumulator oReady.
- iAccRes  in  OUTPUT_LENGTH  from accumulator oRes.
- iAccDone  in  1  from accumulator oDone.
- oResult  out  OUTPUT_LENGTH  captured final sum.
- oResultValid  out  1  one-cycle pulse when oResult is updated.
- oBusy  out  1  high in every state except IDLE.

Behaviour:
- Reset (iRst==0 at an edge): state IDLE; all outputs 0, including oResult; internal counter 0. Reset mid-batch aborts immediately with no terminate issued. The batch is lost.
- FSM states: IDLE, FETCH, ISSUE, SETTLE, WAIT_RDY, TERM, WAIT_DONE, OUT.
- IDLE:
  - iStart==1 latches iCount into the remaining-counter.
  - If iCount!=0, go to FETCH; if iCount==0, go to TERM, so an empty batch yields the accumulator's cleared result.
  - iStart in any other state is ignored.
- FETCH:
  - oDataReady=1, and only while iAccReady==1.
  - On transfer, register iData into oA and go to ISSUE.
  - iValid low stalls indefinitely.
- ISSUE: oAccumulate=1 for exactly one cycle, oA stable; decrement the counter; go to SETTLE.
- SETTLE: one mandatory cycle with iAccReady ignored, so a stale ready is not mistaken for completion; go to WAIT_RDY.
- WAIT_RDY:
  - On iAccReady==1, go to FETCH if counter!=0, else TERM.
  - oA holds its value until the next transfer.
- TERM: oTerminate=1 for one cycle; go to WAIT_DONE.
- WAIT_DONE: on iAccDone==1, capture iAccRes into oResult and go to OUT.
- OUT: oResultValid=1 for one cycle; go to IDLE. oResult holds until the next capture or reset.
- Ignored inputs: iAccDone outside WAIT_DONE; iAccReady outside FETCH/WAIT_RDY.
- Exclusivity: oAccumulate and oTerminate are never high together. Neither is high outside ISSUE/TERM.
- Minimum per-operand cost: 1 FETCH + 1 ISSUE + 1 SETTLE + WAIT_RDY (≥1) = 4 cycles when iValid and iAccReady are already high.
- Zero-latency end: batch end to oResultValid with zero accumulator latency = TERM + WAIT_DONE + OUT = 3 cycles.
- No arithmetic is performed here. Width adaptation is the accumulator's job; oResult is a verbatim copy of iAccRes.
- Counter width: the counter is COUNT_WIDTH bits; iCount=2^COUNT_WIDTH-1 must complete without wrap.

Test Plan:
- Nominal batch: iCount=16, operands 0701,00F1,10B7,A2C1 repeated 4×, behavioural accumulator with ready dropping for 3 cycles after each accumulate. Required: exactly 16 oAccumulate pulses, 1 oTerminate, then oResult=32'h0002EDA8 with a one-cycle oResultValid.
- Upstream stall: same batch with iValid low for 5 random cycles between operands. Required: oAccumulate count stays 16, same result, oA never changes while oAccumulate=1.
- Empty batch: iCount=0. Required: no oAccumulate, one oTerminate 1 cycle after iStart, oResult=iAccRes value (0) and oResultValid.
- Ready never drops: accumulator model holds iAccReady=1 continuously, iCount=4. Required: pulses exactly 4 cycles apart, SETTLE respected, sum 32'h0000BB6A.
- Reset mid-batch: iRst=0 after 7 operands. Required: next cycle all outputs 0, oBusy=0; a fresh iCount=1, data 0001 batch then yields 32'h00000001 from a re-reset model.
- Spurious inputs: iStart pulses and iAccDone pulses during FETCH/WAIT_RDY. Required: no state disturbance and no extra oResultValid; final result unchanged.
